// File: rtl/multi_mode_sequence_counter_if.sv
// Bus bundle for multi_mode_sequence_counter: control inputs and sequence outputs.
// The master side drives en/load/load_val/mode; the slave (the counter) drives counter/tc/wrap.
interface multi_mode_sequence_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [2:0]       mode;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             wrap;

  modport master (
    output en, load, load_val, mode,
    input  counter, tc, wrap
  );

  modport slave (
    input  en, load, load_val, mode,
    output counter, tc, wrap
  );
endinterface

// File: rtl/multi_mode_sequence_counter.sv
// Multi-mode sequence counter: binary up/down, Gray, Johnson from one state register.
// Optional Fibonacci LFSR in mode 100 when SEQ_CNT_LFSR_EN is defined (WIDTH 3..8 only).
module multi_mode_sequence_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input logic                       clk,
  input logic                       reset,
  multi_mode_sequence_counter_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_UP      = 3'b000,
    MODE_DOWN    = 3'b001,
    MODE_GRAY    = 3'b010,
    MODE_JOHNSON = 3'b011,
    MODE_LFSR    = 3'b100,
    MODE_HOLD5   = 3'b101,
    MODE_HOLD6   = 3'b110,
    MODE_HOLD7   = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] JOHNSON_TC = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_nxt;
  mode_e            mode_q;
  mode_e            mode_nxt;
  logic             wrap_q;
  logic             wrap_nxt;
  logic [WIDTH-1:0] johnson_next;

`ifdef SEQ_CNT_LFSR_EN
  localparam bit LFSR_ON = (WIDTH >= 3) && (WIDTH <= 8);

  logic             lfsr_fb;
  logic [WIDTH-1:0] lfsr_next;

  // Maximal-length tap sets; widths without a table entry never enable the LFSR.
  generate
    if (WIDTH == 3) begin : g_taps3
      assign lfsr_fb = state[2] ^ state[1];
    end else if (WIDTH == 4) begin : g_taps4
      assign lfsr_fb = state[3] ^ state[2];
    end else if (WIDTH == 5) begin : g_taps5
      assign lfsr_fb = state[4] ^ state[2];
    end else if (WIDTH == 6) begin : g_taps6
      assign lfsr_fb = state[5] ^ state[4];
    end else if (WIDTH == 7) begin : g_taps7
      assign lfsr_fb = state[6] ^ state[5];
    end else if (WIDTH == 8) begin : g_taps8
      assign lfsr_fb = state[7] ^ state[5] ^ state[4] ^ state[3];
    end else begin : g_taps_none
      assign lfsr_fb = 1'b0;
    end
  endgenerate

  assign lfsr_next = {state[WIDTH-2:0], lfsr_fb};
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  assign johnson_next = {state[WIDTH-2:0], ~state[WIDTH-1]};

  function automatic logic is_hold(input mode_e m);
    logic hold;
    hold = 1'b0;
    case (m)
      MODE_LFSR:                          hold = !LFSR_ON;
      MODE_HOLD5, MODE_HOLD6, MODE_HOLD7: hold = 1'b1;
      default:                            hold = 1'b0;
    endcase
    return hold;
  endfunction

  // Value the state takes when a new mode is entered; the LFSR must never sit at zero.
  function automatic logic [WIDTH-1:0] entry_value(input mode_e m);
    logic [WIDTH-1:0] v;
    v = '0;
    if (m == MODE_LFSR && LFSR_ON) begin
      v = ALL_ONES;
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= '0;
      mode_q <= MODE_UP;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // Priority: mode change, then load, then en; hold modes ignore both load and en.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    wrap_nxt  = 1'b0;
    if (bus.mode != mode_q) begin
      mode_nxt  = mode_e'(bus.mode);
      state_nxt = entry_value(mode_e'(bus.mode));
    end else if (is_hold(mode_q)) begin
      state_nxt = state;
    end else if (bus.load) begin
      case (mode_q)
        MODE_UP, MODE_DOWN, MODE_GRAY: state_nxt = clamp(bus.load_val);
        MODE_JOHNSON:                  state_nxt = bus.load_val;
`ifdef SEQ_CNT_LFSR_EN
        MODE_LFSR:                     state_nxt = (bus.load_val == '0) ? ALL_ONES : bus.load_val;
`endif
        default:                       state_nxt = state;
      endcase
    end else if (bus.en) begin
      case (mode_q)
        MODE_UP, MODE_GRAY: begin
          if (state == MAX_VAL) begin
            state_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            state_nxt = state + ONE;
          end
        end
        MODE_DOWN: begin
          if (state == '0) begin
            state_nxt = MAX_VAL;
            wrap_nxt  = 1'b1;
          end else begin
            state_nxt = state - ONE;
          end
        end
        MODE_JOHNSON: begin
          state_nxt = johnson_next;
          wrap_nxt  = (johnson_next == '0);
        end
`ifdef SEQ_CNT_LFSR_EN
        MODE_LFSR: begin
          state_nxt = lfsr_next;
          wrap_nxt  = (lfsr_next == ALL_ONES);
        end
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bus.counter = state;
    bus.tc      = 1'b0;
    case (mode_q)
      MODE_UP:      bus.tc = (state == MAX_VAL);
      MODE_DOWN:    bus.tc = (state == '0);
      MODE_GRAY: begin
        bus.counter = state ^ (state >> 1);
        bus.tc      = (state == MAX_VAL);
      end
      MODE_JOHNSON: bus.tc = (state == JOHNSON_TC);
      default:      bus.tc = 1'b0;
    endcase
  end

  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_multi_mode_sequence_counter.sv
// Testbench for multi_mode_sequence_counter: one instance with MAX_COUNT=9, one with full range.
// Table vectors, hand sequences and randomized traffic are checked against a behavioural model.
module tb_multi_mode_sequence_counter;

  localparam int W = 4;

`ifdef SEQ_CNT_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  multi_mode_sequence_counter_if #(.WIDTH(W)) bus_a ();
  multi_mode_sequence_counter_if #(.WIDTH(W)) bus_b ();

  multi_mode_sequence_counter #(.WIDTH(W), .MAX_COUNT(9)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  multi_mode_sequence_counter #(.WIDTH(W), .MAX_COUNT(15)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  typedef struct {
    bit       en;
    bit       load;
    bit [3:0] load_val;
    bit [2:0] mode;
    int       exp_counter;
    bit       exp_tc;
    bit       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  int m_state[2];
  int m_mode[2];
  bit m_wrap[2];
  int max_of[2] = '{9, 15};

  function automatic bit model_hold(int mode);
    return (mode >= 5) || (mode == 4 && !LFSR_ON);
  endfunction

  function automatic int model_counter(int i);
    if (m_mode[i] == 2) return m_state[i] ^ (m_state[i] >> 1);
    return m_state[i];
  endfunction

  function automatic bit model_tc(int i);
    case (m_mode[i])
      0, 2:    return m_state[i] == max_of[i];
      1:       return m_state[i] == 0;
      3:       return m_state[i] == 8;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_mode[i]  = 0;
      m_wrap[i]  = 1'b0;
    end
  endtask

  // Sequence rules as modular arithmetic on the count value, one step per edge.
  task automatic model_edge(bit en, bit load, int lv, int mode);
    for (int i = 0; i < 2; i++) begin
      int s;
      int mx;
      bit w;
      s  = m_state[i];
      mx = max_of[i];
      w  = 1'b0;
      if (mode != m_mode[i]) begin
        m_mode[i] = mode;
        s = (mode == 4 && LFSR_ON) ? 15 : 0;
      end else if (model_hold(mode)) begin
        s = s;
      end else if (load) begin
        if (mode <= 2)      s = (lv > mx) ? mx : lv;
        else if (mode == 3) s = lv;
        else                s = (lv == 0) ? 15 : lv;
      end else if (en) begin
        case (mode)
          0, 2: begin
            s = (s + 1) % (mx + 1);
            w = (s == 0);
          end
          1: begin
            w = (s == 0);
            s = (s + mx) % (mx + 1);
          end
          3: begin
            s = ((s * 2) % 16) + (((s / 8) % 2) == 1 ? 0 : 1);
            w = (s == 0);
          end
          default: begin
            s = ((s * 2) % 16) + (((s / 8) + (s / 4)) % 2);
            w = (s == 15);
          end
        endcase
      end
      m_state[i] = s;
      m_wrap[i]  = w;
    end
  endtask

  task automatic check_value(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_output(string tag);
    check_value({tag, " a.counter"}, int'(bus_a.counter), model_counter(0));
    check_value({tag, " a.tc"},      int'(bus_a.tc),      int'(model_tc(0)));
    check_value({tag, " a.wrap"},    int'(bus_a.wrap),    int'(m_wrap[0]));
    check_value({tag, " b.counter"}, int'(bus_b.counter), model_counter(1));
    check_value({tag, " b.tc"},      int'(bus_b.tc),      int'(model_tc(1)));
    check_value({tag, " b.wrap"},    int'(bus_b.wrap),    int'(m_wrap[1]));
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic apply_stimulus(bit en, bit load, bit [3:0] lv, bit [2:0] mode, string tag);
    bus_a.en = en;   bus_a.load = load;   bus_a.load_val = lv;   bus_a.mode = mode;
    bus_b.en = en;   bus_b.load = load;   bus_b.load_val = lv;   bus_b.mode = mode;
    @(posedge clk);
    model_edge(en, load, int'(lv), int'(mode));
    @(negedge clk);
    check_output(tag);
  endtask

  function automatic void add_vec(bit en, bit load, bit [3:0] lv, bit [2:0] mode,
                                  int c, bit tc, bit wrap);
    vec_t v;
    v.en = en; v.load = load; v.load_val = lv; v.mode = mode;
    v.exp_counter = c; v.exp_tc = tc; v.exp_wrap = wrap;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [2:0] cur_mode;

    for (int k = 1; k <= 9; k++) add_vec(1, 0, 0, 0, k, k == 9, 0);
    add_vec(1, 0, 0,  0, 0, 0, 1);
    add_vec(1, 1, 12, 0, 9, 1, 0);
    add_vec(1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 5,  0, 5, 0, 0);
    add_vec(0, 0, 0,  0, 5, 0, 0);
    add_vec(1, 1, 3,  1, 0, 1, 0);
    add_vec(1, 0, 0,  1, 9, 0, 1);
    add_vec(1, 0, 0,  1, 8, 0, 0);
    add_vec(0, 0, 0,  1, 8, 0, 0);
    add_vec(1, 0, 0,  3, 0, 0, 0);
    add_vec(1, 0, 0,  3, 1,  0, 0);
    add_vec(1, 0, 0,  3, 3,  0, 0);
    add_vec(1, 0, 0,  3, 7,  0, 0);
    add_vec(1, 0, 0,  3, 15, 0, 0);
    add_vec(1, 0, 0,  3, 14, 0, 0);
    add_vec(1, 0, 0,  3, 12, 0, 0);
    add_vec(1, 0, 0,  3, 8,  1, 0);
    add_vec(1, 0, 0,  3, 0,  0, 1);
    add_vec(1, 0, 0,  5, 0,  0, 0);
    add_vec(1, 1, 7,  5, 0,  0, 0);
    add_vec(1, 0, 0,  4, LFSR_ON ? 15 : 0, 0, 0);
    add_vec(1, 1, 6,  4, LFSR_ON ? 6 : 0,  0, 0);
    add_vec(1, 0, 0,  2, 0, 0, 0);
    add_vec(1, 0, 0,  2, 1, 0, 0);
    add_vec(1, 0, 0,  2, 3, 0, 0);
    add_vec(1, 0, 0,  2, 2, 0, 0);

    bus_a.en = 0; bus_a.load = 0; bus_a.load_val = 0; bus_a.mode = 0;
    bus_b.en = 0; bus_b.load = 0; bus_b.load_val = 0; bus_b.mode = 0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_output("reset");
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] table vectors (MAX_COUNT=9 instance)");
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply_stimulus(vecs[i].en, vecs[i].load, vecs[i].load_val, vecs[i].mode, tag);
      check_value({tag, " tbl.counter"}, int'(bus_a.counter), vecs[i].exp_counter);
      check_value({tag, " tbl.tc"},      int'(bus_a.tc),      int'(vecs[i].exp_tc));
      check_value({tag, " tbl.wrap"},    int'(bus_a.wrap),    int'(vecs[i].exp_wrap));
    end

    $display("[TB] full-range Gray cycle");
    apply_stimulus(1, 0, 0, 0, "gray_pre");
    apply_stimulus(1, 0, 0, 2, "gray_enter");
    check_value("gray_enter b.counter", int'(bus_b.counter), 0);
    for (int k = 1; k <= 16; k++) begin
      int n;
      n = k % 16;
      apply_stimulus(1, 0, 0, 2, "gray");
      check_value($sformatf("gray%0d b.counter", k), int'(bus_b.counter), n ^ (n >> 1));
      check_value($sformatf("gray%0d b.tc", k),      int'(bus_b.tc),      int'(n == 15));
      check_value($sformatf("gray%0d b.wrap", k),    int'(bus_b.wrap),    int'(k == 16));
    end

`ifdef SEQ_CNT_LFSR_EN
    $display("[TB] LFSR full period");
    apply_stimulus(1, 0, 0, 4, "lfsr_enter");
    check_value("lfsr_enter b.counter", int'(bus_b.counter), 15);
    for (int k = 1; k <= 15; k++) apply_stimulus(1, 0, 0, 4, "lfsr");
    check_value("lfsr_period b.counter", int'(bus_b.counter), 15);
    check_value("lfsr_period b.wrap",    int'(bus_b.wrap),    1);
`else
    $display("[TB] mode 100 behaves as hold");
    apply_stimulus(1, 0, 0, 0, "hold_pre");
    apply_stimulus(1, 0, 0, 4, "hold_enter");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, k == 1, 4'd7, 4, "hold");
      check_value("hold4 a.counter", int'(bus_a.counter), 0);
      check_value("hold4 a.wrap",    int'(bus_a.wrap),    0);
    end
`endif

    $display("[TB] asynchronous reset mid-count");
    apply_stimulus(1, 0, 0, 0, "ar_enter");
    apply_stimulus(1, 0, 0, 0, "ar_count");
    apply_stimulus(1, 0, 0, 0, "ar_count");
    check_value("ar_before a.counter", int'(bus_a.counter), 2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_value("ar_immediate a.counter", int'(bus_a.counter), 0);
    check_value("ar_immediate b.counter", int'(bus_b.counter), 0);
    @(negedge clk);
    check_output("ar_held");
    reset = 1'b1;
    apply_stimulus(1, 0, 0, 0, "ar_resume");
    check_value("ar_resume a.counter", int'(bus_a.counter), 1);

    $display("[TB] randomized traffic");
    cur_mode = 3'd0;
    for (int k = 0; k < 400; k++) begin
      bit       en;
      bit       ld;
      bit [3:0] lv;
      if ($urandom_range(0, 11) == 0) cur_mode = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 9) < 7);
      ld = ($urandom_range(0, 9) < 1);
      lv = 4'($urandom_range(0, 15));
      apply_stimulus(en, ld, lv, cur_mode, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_mode_sequence_counter.md
Name: multi_mode_sequence_counter

Overview:
- Parametrised successor to the fixed 4-bit sequence counter.
- Generates one of several count sequences from a single state register: binary up, binary down, Gray, Johnson, and optionally LFSR.
- Has a programmable wrap point, synchronous load, count enable, terminal-count flag and wrap pulse.
- Used as a sequence/address source for downstream test and control blocks.

Parameters:
WIDTH, 4, state and output width; legal 2..16.
MAX_COUNT, 2**WIDTH-1, wrap value for the binary and Gray modes; legal 1..2**WIDTH-1.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state.
en  input  1  advance the sequence one step per clock while high.
load  input  1  synchronous load of load_val; has priority over en.
load_val  input  WIDTH  load value.
mode  input  3  000 up, 001 down, 010 Gray, 011 Johnson, 100 LFSR (optional), others hold.
counter  output  WIDTH  current sequence value.
tc  output  1  high while the state is at the mode's terminal value.
wrap  output  1  one-cycle pulse in the cycle counter shows the wrapped value.

Behaviour:
- Reset (reset=0, asynchronous): state=0, mode_q=000, wrap=0. Therefore counter=0 and tc=0.
- Registers: state[WIDTH-1:0], mode_q[2:0], wrap.
- counter and tc decode from registers only; there is no combinational input-to-output path.
- Counter mapping:
  - Up, down, Johnson, LFSR: counter = state.
  - Gray: counter = state ^ (state>>1).
- Per-edge priority:
  1. Mode change (mode != mode_q): mode_q<=mode; state<=0 (all-ones for LFSR); wrap<=0. Load and en are ignored that cycle.
  2. load: state<=load_val.
     - Up/down/Gray: values > MAX_COUNT clamp to MAX_COUNT.
     - LFSR: load_val=0 loads all-ones.
     - Johnson: loaded unchecked.
     - wrap<=0.
  3. en: advance one step, as below.
  4. Otherwise: hold; wrap<=0.
- Advance rules:
  - Up: MAX_COUNT->0 with wrap<=1; else +1.
  - Down: 0->MAX_COUNT with wrap<=1; else -1.
  - Gray: internal binary up as in Up mode; counter is Gray-encoded.
  - Johnson: state<={state[WIDTH-2:0], ~state[WIDTH-1]}; period 2*WIDTH; wrap<=1 when the next state is 0.
  - Hold modes (101-111, or 100 without the macro): state frozen, tc=0, wrap=0.
- Terminal value (tc):
  - Up/Gray: state==MAX_COUNT.
  - Down: state==0.
  - Johnson: state=={1'b1,{WIDTH-1{1'b0}}}.
- Latency: one clock from an en/load edge to the new counter value. tc follows in the same cycle as counter.
- Reset asserted mid-count: immediate clear. Counting resumes on the first edge with reset=1 and en=1.
- en held low: state, counter and tc are stable; wrap is 0.

Optional Feature:
- Macro: SEQ_CNT_LFSR_EN.
- Defined: mode 100 is a Fibonacci LFSR.
  - Shift: state<={state[WIDTH-2:0], fb}.
  - Maximal taps: W3 (2,1); W4 (3,2); W5 (4,2); W6 (5,4); W7 (6,5); W8 (7,5,4,3).
  - Period 2**WIDTH-1; the zero state is never reached.
  - wrap pulses when the state advances into all-ones.
  - tc is always 0.
  - For WIDTH outside 3..8, mode 100 holds.
- Undefined: no LFSR logic is synthesised; mode 100 behaves as a hold mode.

Test Plan:
1. WIDTH=4, MAX_COUNT=9, mode 000, en=1 after reset release -> counter 0,1,...,9,0. tc=1 only at 9; wrap=1 in the cycle counter returns to 0.
2. Mode 001 from reset -> counter 0,9,8,...,0. tc=1 at 0; wrap=1 when counter shows 9.
3. MAX_COUNT=15, mode 010 -> counter 0000,0001,0011,0010,0110,0111,0101,0100,...; wrap at the 1000->0000 transition.
4. Mode 011 -> counter 0000,0001,0011,0111,1111,1110,1100,1000,0000. tc=1 at 1000; wrap at 0000.
5. MAX_COUNT=9: load=1 with load_val=12 together with en=1 -> counter=9 next cycle, tc=1. Then a mode change 000->001 -> counter=0. Then reset=0 mid-count -> counter=0 immediately, without waiting for a clock edge.
6. SEQ_CNT_LFSR_EN defined, WIDTH=4, mode 100 -> 1111,1110,1100,1000,0001,...; returns to 1111 after 15 steps with wrap=1. Without the macro -> counter holds its value after the mode change.
